csr_exec: RTL and testbench
===========================

CSR_EXEC -- requirements
Module: csr_exec

Interface
REQ-001 SHALL have parameter: CSR_LAT, default 1, number of cycles from csr_re asserted to csr_rdata valid (range 1-4).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: i_valid  input  1  decoded CSR instruction offered.
REQ-006 SHALL have port: o_ready  output  1  block can accept an instruction.
REQ-007 SHALL have port: i_funct3  input  3  instruction funct3.
REQ-008 SHALL have port: i_csr_addr  input  12  target CSR address.
REQ-009 SHALL have port: i_rs1_data  input  32  rs1 register value.
REQ-010 SHALL have port: i_rs1_idx  input  5  rs1 index; for the I-forms this field is also zimm.
REQ-011 SHALL have port: i_rd_idx  input  5  destination register index.
REQ-012 SHALL have port: csr_re  output  1  CSR read strobe.
REQ-013 SHALL have port: csr_we  output  1  CSR write strobe.
REQ-014 SHALL have port: csr_addr  output  12  CSR address to the register file.
REQ-015 SHALL have port: csr_funct3  output  4  funct3, zero-extended, to the register file.
REQ-016 SHALL have port: csr_wdata  output  32  write operand.
REQ-017 SHALL have port: csr_rdata  input  32  CSR read data.
REQ-018 SHALL have port: o_valid  output  1  result pulse.
REQ-019 SHALL have port: o_rd_idx  output  5  destination index of the result.
REQ-020 SHALL have port: o_rd_data  output  32  old CSR value to write to rd.
REQ-021 SHALL have port: o_illegal  output  1  illegal-instruction flag, valid with o_valid.

Function
REQ-022 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE.
REQ-023 SHALL assert o_ready only in IDLE while rst=0.
REQ-024 SHALL accept an instruction on a clock edge where i_valid=1 and o_ready=1, and register funct3, address, operand and rd index at that edge.
REQ-025 SHALL form the operand as i_rs1_data for funct3 001/010/011, and as {27'b0, i_rs1_idx} for funct3 101/110/111.
REQ-026 SHALL treat funct3 000 and 100 as illegal.
REQ-027 SHALL treat as illegal any address outside this set: 305, 302, 303, 304, 344, 341, 342, 343, B00, 141, 142, 143, 180, 140 (hex).
REQ-028 SHALL transition IDLE->DONE on accepting an illegal instruction, with o_illegal=1, o_rd_data=0, no csr_re and no csr_we.
REQ-029 SHALL transition IDLE->READ on a legal accept.
REQ-030 SHALL in READ assert csr_re=1 for exactly one cycle, then go to WAIT.
REQ-031 SHALL remain in WAIT for CSR_LAT cycles, capture csr_rdata on the last WAIT cycle, then go to WRITE.
REQ-032 SHALL in WRITE assert csr_we=1 for one cycle with csr_wdata=operand, unless the write is suppressed; then go to DONE.
REQ-033 SHALL suppress the write (csr_we=0 in WRITE) for CSRRS/CSRRC when i_rs1_idx=0 and for CSRRSI/CSRRCI when zimm=0; CSRRW/CSRRWI SHALL always write.
REQ-034 SHALL drive csr_addr and csr_funct3 from the registered values during READ, WAIT and WRITE, and 0 otherwise.
REQ-035 SHALL drive csr_wdata from the operand in WRITE, and 0 otherwise.
REQ-036 SHALL in DONE assert o_valid=1 for exactly one cycle with o_rd_idx and o_rd_data (captured value), then return to IDLE.
REQ-037 SHALL hold o_rd_idx, o_rd_data and o_illegal at 0 whenever o_valid=0.
REQ-038 SHALL have latency, for a legal instruction, from accept edge to o_valid of CSR_LAT+3 cycles (4 with the default).
REQ-039 SHALL have latency, for an illegal instruction, from accept edge to o_valid of 1 cycle.
REQ-040 SHALL ignore i_valid in all states other than IDLE, with no queuing.
REQ-041 SHALL never assert csr_re and csr_we in the same cycle.

Reset
REQ-042 SHALL on rst=1, immediately and without waiting for a clock edge, force state to IDLE and all outputs to 0, including o_ready, csr_re and csr_we.
REQ-043 SHALL abort any in-flight instruction on reset, with no later o_valid and no csr_we for it.
REQ-044 SHALL raise o_ready to 1 on the first cycle after rst deasserts.

Verification
REQ-045 SHALL pass: CSRRW, addr 305, rs1_data 0x0000_1000, csr_rdata 0x0000_0040 -> csr_re at T+1; csr_we at T+3 with wdata 0x1000 and funct3 1; o_valid at T+4 with o_rd_data 0x40.
REQ-046 SHALL pass: CSRRS, addr 344, rs1_idx 0 -> csr_re pulses, csr_we stays 0, o_valid at T+4.
REQ-047 SHALL pass: CSRRCI, addr 304, zimm 5'h1F -> csr_wdata 0x0000_001F, csr_funct3 7.
REQ-048 SHALL pass: funct3 100, or addr 0x7C0 -> o_valid with o_illegal=1 at T+1, no csr_re and no csr_we.
REQ-049 SHALL pass: rst asserted during WAIT -> outputs 0 asynchronously, no csr_we and no o_valid, o_ready=1 one cycle after release.
REQ-050 SHALL pass: i_valid held high through one full operation -> second accept occurs only after returning to IDLE; with CSR_LAT=3, o_valid at T+6.

Source files
------------

// File: rtl/csr_exec_if.sv
// -----------------------------------------------------------------------------
// csr_exec_if -- bundle of the instruction-side handshake, the CSR register
// file bus and the result channel of csr_exec.
//
//   Instruction side : i_valid, o_ready, i_funct3, i_csr_addr, i_rs1_data,
//                      i_rs1_idx (also zimm), i_rd_idx
//   CSR file side    : csr_re, csr_we, csr_addr, csr_funct3, csr_wdata,
//                      csr_rdata
//   Result side      : o_valid, o_rd_idx, o_rd_data, o_illegal
//
// slave  : the csr_exec block itself.
// master : whatever surrounds it (pipeline + register file, or a testbench).
// -----------------------------------------------------------------------------
interface csr_exec_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [11:0] i_csr_addr;
  logic [31:0] i_rs1_data;
  logic [4:0]  i_rs1_idx;
  logic [4:0]  i_rd_idx;

  logic        csr_re;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [3:0]  csr_funct3;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  logic        o_valid;
  logic [4:0]  o_rd_idx;
  logic [31:0] o_rd_data;
  logic        o_illegal;

  modport slave (
    input  i_valid, i_funct3, i_csr_addr, i_rs1_data, i_rs1_idx, i_rd_idx,
    input  csr_rdata,
    output o_ready,
    output csr_re, csr_we, csr_addr, csr_funct3, csr_wdata,
    output o_valid, o_rd_idx, o_rd_data, o_illegal
  );

  modport master (
    output i_valid, i_funct3, i_csr_addr, i_rs1_data, i_rs1_idx, i_rd_idx,
    output csr_rdata,
    input  o_ready,
    input  csr_re, csr_we, csr_addr, csr_funct3, csr_wdata,
    input  o_valid, o_rd_idx, o_rd_data, o_illegal
  );
endinterface

// File: rtl/csr_exec.sv
// -----------------------------------------------------------------------------
// csr_exec -- executes one decoded Zicsr instruction at a time.
//
// A legal instruction is run as a read-modify-write sequence against an
// external CSR register file: one read strobe, CSR_LAT cycles of waiting for
// read data, one (possibly suppressed) write strobe carrying the operand and
// funct3, then a one-cycle result pulse carrying the old CSR value for rd.
// Illegal encodings or unknown CSR addresses skip the bus entirely and produce
// a result pulse with o_illegal set on the next cycle.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; aborts any in-flight instruction
//   bus  csr_exec_if.slave (instruction handshake, CSR bus, result channel)
//
// Parameter:
//   CSR_LAT  cycles from csr_re to valid csr_rdata, 1..4
// -----------------------------------------------------------------------------
module csr_exec #(
  parameter int unsigned CSR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  csr_exec_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // WAIT counts down from CSR_LAT-1 to 0; read data is sampled on the 0 cycle.
  localparam logic [1:0] WAIT_INIT = 2'(CSR_LAT - 1);

  state_t      r_state;
  logic [1:0]  r_wait_cnt;
  logic [31:0] r_operand;
  logic [4:0]  r_rd_idx;
  logic        r_do_write;
  logic [31:0] r_rdata;

  logic        r_ready;
  logic        r_csr_re;
  logic        r_csr_we;
  logic [11:0] r_csr_addr;
  logic [3:0]  r_csr_funct3;
  logic [31:0] r_csr_wdata;
  logic        r_valid;
  logic [4:0]  r_out_rd_idx;
  logic [31:0] r_out_rd_data;
  logic        r_out_illegal;

  logic        w_addr_legal;
  logic        w_funct3_legal;
  logic        w_legal;
  logic [31:0] w_operand;
  logic        w_do_write;

  // Implemented machine-mode and supervisor-mode CSRs plus cycle counter.
  always_comb begin
    // NOTE: default first so that every path assigns the signal; a missing
    // assignment in some branch would otherwise infer a latch.
    w_addr_legal = 1'b0;
    case (bus.i_csr_addr)
      12'h305, 12'h302, 12'h303, 12'h304,
      12'h344, 12'h341, 12'h342, 12'h343,
      12'hB00,
      12'h141, 12'h142, 12'h143, 12'h180, 12'h140: w_addr_legal = 1'b1;
      default: w_addr_legal = 1'b0;
    endcase
  end

  // funct3 x00 is not a CSR operation (000 = ECALL/EBREAK space, 100 reserved).
  assign w_funct3_legal = (bus.i_funct3[1:0] != 2'b00);
  assign w_legal        = w_funct3_legal && w_addr_legal;

  // funct3[2] selects the immediate forms, where the rs1 field is zimm.
  assign w_operand = bus.i_funct3[2] ? {27'b0, bus.i_rs1_idx} : bus.i_rs1_data;

  // Set/clear with rs1=x0 (or zimm=0) must not write, so that reading a CSR
  // with side effects on write stays side-effect free; swap always writes.
  assign w_do_write = (bus.i_funct3[1:0] == 2'b01) || (bus.i_rs1_idx != 5'd0);

  // All outputs are registered: each transition loads the output values that
  // belong to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_wait_cnt    <= 2'd0;
      r_operand     <= 32'd0;
      r_rd_idx      <= 5'd0;
      r_do_write    <= 1'b0;
      r_rdata       <= 32'd0;
      r_ready       <= 1'b0;
      r_csr_re      <= 1'b0;
      r_csr_we      <= 1'b0;
      r_csr_addr    <= 12'd0;
      r_csr_funct3  <= 4'd0;
      r_csr_wdata   <= 32'd0;
      r_valid       <= 1'b0;
      r_out_rd_idx  <= 5'd0;
      r_out_rd_data <= 32'd0;
      r_out_illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register here sees
      // the pre-edge value of every other, regardless of statement order.
      case (r_state)
        IDLE: begin
          if (!r_ready) begin
            // First cycle out of reset: advertise readiness before accepting.
            r_ready <= 1'b1;
          end else if (bus.i_valid) begin
            r_ready    <= 1'b0;
            r_operand  <= w_operand;
            r_rd_idx   <= bus.i_rd_idx;
            r_do_write <= w_do_write;
            if (w_legal) begin
              r_state      <= READ;
              r_csr_re     <= 1'b1;
              r_csr_addr   <= bus.i_csr_addr;
              r_csr_funct3 <= {1'b0, bus.i_funct3};
            end else begin
              r_state       <= DONE;
              r_valid       <= 1'b1;
              r_out_illegal <= 1'b1;
              r_out_rd_idx  <= bus.i_rd_idx;
              r_out_rd_data <= 32'd0;
            end
          end
        end

        READ: begin
          r_csr_re   <= 1'b0;
          r_wait_cnt <= WAIT_INIT;
          r_state    <= WAIT;
        end

        WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_rdata     <= bus.csr_rdata;
            r_csr_we    <= r_do_write;
            r_csr_wdata <= r_operand;
            r_state     <= WRITE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end

        WRITE: begin
          r_csr_we      <= 1'b0;
          r_csr_wdata   <= 32'd0;
          r_csr_addr    <= 12'd0;
          r_csr_funct3  <= 4'd0;
          r_valid       <= 1'b1;
          r_out_rd_idx  <= r_rd_idx;
          r_out_rd_data <= r_rdata;
          r_out_illegal <= 1'b0;
          r_state       <= DONE;
        end

        DONE: begin
          r_valid       <= 1'b0;
          r_out_rd_idx  <= 5'd0;
          r_out_rd_data <= 32'd0;
          r_out_illegal <= 1'b0;
          r_ready       <= 1'b1;
          r_state       <= IDLE;
        end

        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready    = r_ready;
  assign bus.csr_re     = r_csr_re;
  assign bus.csr_we     = r_csr_we;
  assign bus.csr_addr   = r_csr_addr;
  assign bus.csr_funct3 = r_csr_funct3;
  assign bus.csr_wdata  = r_csr_wdata;
  assign bus.o_valid    = r_valid;
  assign bus.o_rd_idx   = r_out_rd_idx;
  assign bus.o_rd_data  = r_out_rd_data;
  assign bus.o_illegal  = r_out_illegal;

endmodule

// File: tb/tb_csr_exec.sv
// -----------------------------------------------------------------------------
// tb_csr_exec -- self-checking bench for csr_exec.
//
// u_dut  : default CSR_LAT=1, driven by directed vectors, random instructions
//          and a reset-abort sequence. A small register-file model answers
//          reads after the configured latency (garbage on other cycles) and
//          applies writes; an independent shadow of CSR contents predicts
//          the old value returned in rd.
// u_dut3 : CSR_LAT=3, used for the held-i_valid back-to-back sequence.
// -----------------------------------------------------------------------------
module tb_csr_exec;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  localparam logic [11:0] LEGAL [14] = '{
    12'h305, 12'h302, 12'h303, 12'h304, 12'h344, 12'h341, 12'h342,
    12'h343, 12'hB00, 12'h141, 12'h142, 12'h143, 12'h180, 12'h140
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_exec_if bus ();
  csr_exec_if bus3 ();

  csr_exec u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  csr_exec #(.CSR_LAT(LAT3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rf_mem  [4096];  // contents seen by the DUT's register file
  logic [31:0] ref_csr [4096];  // contents predicted from instruction rules
  int          rd_cnt = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  idx;
    logic [4:0]  rd;
    logic [31:0] preset;
    logic        exp_ill;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] csr_update(input logic [1:0] kind, input logic [31:0] old_v,
                                             input logic [31:0] op);
    case (kind)
      2'b01:   return op;
      2'b10:   return old_v | op;
      2'b11:   return old_v & ~op;
      default: return old_v;
    endcase
  endfunction

  function automatic bit addr_in_set(input logic [11:0] a);
    for (int k = 0; k < 14; k++) if (LEGAL[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Register-file model: read data is valid only on the cycle the DUT must
  // sample it (LAT cycles after the read strobe); writes follow funct3.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      rd_cnt = 0;
    end else begin
      if (bus.csr_we)
        rf_mem[bus.csr_addr] = csr_update(bus.csr_funct3[1:0], rf_mem[bus.csr_addr], bus.csr_wdata);
      if (bus.csr_re) rd_cnt = LAT + 1;
      else if (rd_cnt > 0) rd_cnt--;
    end
    bus.csr_rdata = (rd_cnt == 1) ? rf_mem[bus.csr_addr] : $urandom();
  end

  // Run one instruction on u_dut, observe it cycle by cycle, compare to the
  // expected outcome. Cycle j = value visible j edges after the accept edge
  // minus one, i.e. "at T+j".
  task automatic do_txn(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] idx, input logic [4:0] rd,
                        input logic exp_ill, input logic exp_we, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rd);
    int          wait_n, valid_j, re_cnt, re_j, we_cnt, we_j, wr_j;
    logic [31:0] wdata_at, rd_data_at;
    logic [4:0]  rd_idx_at;
    logic        ill_at;
    logic [11:0] we_addr;
    logic [3:0]  we_f3;
    bit          rules_ok;
    wait_n = 0; valid_j = 0; re_cnt = 0; re_j = 0; we_cnt = 0; we_j = 0;
    wr_j = LAT + 2;
    wdata_at = '0; rd_data_at = '0; rd_idx_at = '0; ill_at = 1'b0;
    we_addr = '0; we_f3 = '0; rules_ok = 1'b1;

    @(negedge clk);
    while (!bus.o_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, ":ready"}, 32'(bus.o_ready), 32'd1);

    bus.i_funct3   = f3;
    bus.i_csr_addr = addr;
    bus.i_rs1_data = rs1;
    bus.i_rs1_idx  = idx;
    bus.i_rd_idx   = rd;
    bus.i_valid    = 1'b1;
    @(posedge clk);

    for (int j = 1; j <= LAT + 8; j++) begin
      @(negedge clk);
      if (j == 1) bus.i_valid = 1'b0;
      if (bus.csr_re && bus.csr_we) rules_ok = 1'b0;
      if (bus.o_ready) rules_ok = 1'b0;
      if (!bus.o_valid && (bus.o_rd_idx != 5'd0 || bus.o_rd_data != 32'd0 || bus.o_illegal))
        rules_ok = 1'b0;
      if (!exp_ill && j <= wr_j) begin
        if (bus.csr_addr != addr || bus.csr_funct3 != {1'b0, f3}) rules_ok = 1'b0;
      end else begin
        if (bus.csr_addr != 12'd0 || bus.csr_funct3 != 4'd0) rules_ok = 1'b0;
      end
      if (!(j == wr_j && !exp_ill) && bus.csr_wdata != 32'd0) rules_ok = 1'b0;
      if (j == wr_j) wdata_at = bus.csr_wdata;
      if (bus.csr_re) begin re_cnt++; re_j = j; end
      if (bus.csr_we) begin
        we_cnt++; we_j = j; we_addr = bus.csr_addr; we_f3 = bus.csr_funct3;
      end
      if (bus.o_valid) begin
        valid_j = j; rd_data_at = bus.o_rd_data; rd_idx_at = bus.o_rd_idx; ill_at = bus.o_illegal;
        break;
      end
    end
    bus.i_valid = 1'b0;

    check({tag, ":valid_cycle"}, 32'(valid_j), exp_ill ? 32'd1 : 32'(LAT + 3));
    check({tag, ":illegal"}, 32'(ill_at), 32'(exp_ill));
    check({tag, ":rd_data"}, rd_data_at, exp_rd);
    check({tag, ":re_count"}, 32'(re_cnt), exp_ill ? 32'd0 : 32'd1);
    check({tag, ":we_count"}, 32'(we_cnt), 32'(exp_we));
    check({tag, ":bus_rules"}, 32'(rules_ok), 32'd1);
    if (!exp_ill) begin
      check({tag, ":rd_idx"}, 32'(rd_idx_at), 32'(rd));
      check({tag, ":re_cycle"}, 32'(re_j), 32'd1);
      check({tag, ":wdata"}, wdata_at, exp_wdata);
    end
    if (exp_we) begin
      check({tag, ":we_cycle"}, 32'(we_j), 32'(wr_j));
      check({tag, ":we_addr"}, 32'(we_addr), 32'(addr));
      check({tag, ":we_funct3"}, 32'(we_f3), 32'({1'b0, f3}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap, op;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  idx, rd;
    logic        legal, we;
    bit          bad;
    int          v_j, we_j3, re1_cnt, re2_j, rdy_j, mism;
    logic [31:0] rd3;

    bus.i_valid = 0; bus.i_funct3 = 0; bus.i_csr_addr = 0; bus.i_rs1_data = 0;
    bus.i_rs1_idx = 0; bus.i_rd_idx = 0;
    bus3.i_valid = 0; bus3.i_funct3 = 0; bus3.i_csr_addr = 0; bus3.i_rs1_data = 0;
    bus3.i_rs1_idx = 0; bus3.i_rd_idx = 0; bus3.csr_rdata = 32'h1234_5678;
    for (int i = 0; i < 4096; i++) begin
      rf_mem[i]  = $urandom();
      ref_csr[i] = rf_mem[i];
    end

    //            f3    addr     rs1           idx    rd     preset        ill we wdata         rd
    vecs[0]  = '{3'd1, 12'h305, 32'h0000_1000, 5'd3,  5'd5,  32'h0000_0040, 0, 1, 32'h0000_1000, 32'h0000_0040};
    vecs[1]  = '{3'd2, 12'h344, 32'h0000_FFFF, 5'd0,  5'd6,  32'h0000_0088, 0, 0, 32'h0000_FFFF, 32'h0000_0088};
    vecs[2]  = '{3'd7, 12'h304, 32'h0000_DEAD, 5'h1F, 5'd7,  32'hFFFF_FFFF, 0, 1, 32'h0000_001F, 32'hFFFF_FFFF};
    vecs[3]  = '{3'd4, 12'h305, 32'h0000_0001, 5'd1,  5'd8,  32'h0000_0077, 1, 0, 32'h0,         32'h0};
    vecs[4]  = '{3'd1, 12'h7C0, 32'h0000_0001, 5'd1,  5'd9,  32'h0000_0011, 1, 0, 32'h0,         32'h0};
    vecs[5]  = '{3'd0, 12'h341, 32'h0000_0002, 5'd2,  5'd10, 32'h0000_0022, 1, 0, 32'h0,         32'h0};
    vecs[6]  = '{3'd6, 12'h141, 32'h0000_ABCD, 5'd0,  5'd11, 32'h0000_0005, 0, 0, 32'h0,         32'h0000_0005};
    vecs[7]  = '{3'd3, 12'h342, 32'h0000_00F0, 5'd7,  5'd12, 32'h0000_00FF, 0, 1, 32'h0000_00F0, 32'h0000_00FF};
    vecs[8]  = '{3'd5, 12'hB00, 32'h0000_0099, 5'd0,  5'd13, 32'h0000_0123, 0, 1, 32'h0,         32'h0000_0123};
    vecs[9]  = '{3'd2, 12'h180, 32'hDEAD_BEEF, 5'd2,  5'd14, 32'h0,         0, 1, 32'hDEAD_BEEF, 32'h0};
    vecs[10] = '{3'd1, 12'h140, 32'h0000_0001, 5'd1,  5'd15, 32'h0000_CAFE, 0, 1, 32'h0000_0001, 32'h0000_CAFE};
    vecs[11] = '{3'd1, 12'h306, 32'h0000_0001, 5'd1,  5'd16, 32'h0000_0033, 1, 0, 32'h0,         32'h0};

    // Reset: outputs forced low while rst is high, ready one cycle after release.
    rst = 1'b1;
    #1;
    check("reset:ctrl", 32'({bus.o_ready, bus.csr_re, bus.csr_we, bus.o_valid, bus.o_illegal}), 32'd0);
    check("reset:data", bus.csr_wdata | bus.o_rd_data | 32'(bus.csr_addr), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset:ready_after_release", 32'(bus.o_ready), 32'd1);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      rf_mem[vecs[i].addr]  = vecs[i].preset;
      ref_csr[vecs[i].addr] = vecs[i].preset;
      do_txn($sformatf("vec%0d", i), vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].idx,
             vecs[i].rd, vecs[i].exp_ill, vecs[i].exp_we, vecs[i].exp_wdata, vecs[i].exp_rd);
      if (vecs[i].exp_we)
        ref_csr[vecs[i].addr] = csr_update(vecs[i].f3[1:0], vecs[i].preset, vecs[i].exp_wdata);
    end

    // Random instructions against the rule-level model.
    for (int i = 0; i < 60; i++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 9) < 7) ? LEGAL[$urandom_range(0, 13)] : 12'($urandom());
      rs1  = $urandom();
      idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
      rd   = 5'($urandom());
      legal = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd5 || f3 == 3'd6 || f3 == 3'd7)
              && addr_in_set(addr);
      op = (f3 >= 3'd5) ? 32'(idx) : rs1;
      we = legal && (f3 == 3'd1 || f3 == 3'd5 || idx != 5'd0);
      do_txn($sformatf("rnd%0d", i), f3, addr, rs1, idx, rd, !legal, we, op,
             legal ? ref_csr[addr] : 32'd0);
      if (we) ref_csr[addr] = csr_update(f3[1:0], ref_csr[addr], op);
    end
    mism = 0;
    for (int k = 0; k < 14; k++) if (rf_mem[LEGAL[k]] !== ref_csr[LEGAL[k]]) mism++;
    check("rnd:final_csr_contents", 32'(mism), 32'd0);

    // Reset during WAIT aborts the instruction.
    @(negedge clk);
    snap = rf_mem[12'h305];
    bus.i_funct3 = 3'd1; bus.i_csr_addr = 12'h305; bus.i_rs1_data = 32'hAAAA_5555;
    bus.i_rs1_idx = 5'd4; bus.i_rd_idx = 5'd3; bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("abort:in_wait_addr", 32'(bus.csr_addr), 32'h305);
    #2;
    rst = 1'b1;
    #1;
    check("abort:ctrl_async", 32'({bus.o_ready, bus.csr_re, bus.csr_we, bus.o_valid, bus.o_illegal}), 32'd0);
    check("abort:data_async", bus.csr_wdata | 32'(bus.csr_addr) | 32'(bus.csr_funct3), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort:ready_after_release", 32'(bus.o_ready), 32'd1);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.csr_we || bus.o_valid) bad = 1'b1;
    end
    check("abort:no_late_activity", 32'(bad), 32'd0);
    check("abort:csr_unchanged", rf_mem[12'h305], snap);

    // CSR_LAT=3 with i_valid held high across the whole operation.
    @(negedge clk);
    check("lat3:ready", 32'(bus3.o_ready), 32'd1);
    bus3.i_funct3 = 3'd1; bus3.i_csr_addr = 12'h341; bus3.i_rs1_data = 32'h55;
    bus3.i_rs1_idx = 5'd9; bus3.i_rd_idx = 5'd7; bus3.i_valid = 1'b1;
    @(posedge clk);
    v_j = 0; we_j3 = 0; re1_cnt = 0; re2_j = 0; rdy_j = 0; rd3 = '0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (bus3.o_valid && v_j == 0) begin v_j = j; rd3 = bus3.o_rd_data; end
      if (bus3.csr_we && we_j3 == 0) we_j3 = j;
      if (bus3.csr_re && j <= 7) re1_cnt++;
      if (bus3.csr_re && j > 1 && re2_j == 0) re2_j = j;
      if (bus3.o_ready && rdy_j == 0) rdy_j = j;
    end
    bus3.i_valid = 1'b0;
    check("lat3:valid_cycle", 32'(v_j), 32'd6);
    check("lat3:rd_data", rd3, 32'h1234_5678);
    check("lat3:we_cycle", 32'(we_j3), 32'd5);
    check("lat3:single_read_first_op", 32'(re1_cnt), 32'd1);
    check("lat3:ready_cycle", 32'(rdy_j), 32'd7);
    check("lat3:second_accept_read", 32'(re2_j), 32'd8);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
